acc_div_inject: RTL and testbench

- Parametrised successor of the single-operation divide accelerator controller.
- Sits between decode (stage 100–102) and an external iterative divider.
- On a divide request it either serves the result from a small result cache, or runs the divider and waits for it.
- It then injects two-instruction bundles into the instruction stream that write quotient and remainder to data memory.
- Unlike the previous generation it handles any 16-bit result, including MSB-set values, via an inverted-load sequence. It also handles divide-by-zero, and makes memory addresses and widths configurable.

---
 rtl/acc_div_inject_pkg.sv | 39 +++
 rtl/acc_div_inject_if.sv | 40 ++++
 rtl/acc_div_inject_result_cache.sv | 114 +++++++++++
 rtl/acc_div_inject.sv | 218 +++++++++++++++++++++
 tb/tb_acc_div_inject.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/acc_div_inject_pkg.sv
// ============================================================================
// Module      : acc_div_inject_pkg
// Description : Shared types and constants for the divide-accelerator
//               injection controller: the controller state enum, the Hack
//               instruction encodings it injects, and the layout of one
//               result-cache entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_div_inject_pkg;

  // Controller states. The encoding is 3 bits wide, so values 5..7 are
  // illegal and the controller treats them as S_IDLE.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DIV     = 3'd1,
    S_EMIT_LD = 3'd2,
    S_EMIT_ST = 3'd3,
    S_DONE    = 3'd4
  } t_acc_state;

  // Hack C-instructions used by the injected bundles.
  localparam logic [15:0] INST_D_EQ_A     = 16'hEC10;  // D=A
  localparam logic [15:0] INST_D_EQ_NOT_A = 16'hEC50;  // D=!A
  localparam logic [15:0] INST_M_EQ_D     = 16'hE308;  // M=D

  // Result-cache entry layout for the native 16-bit Hack word.
  typedef struct packed {
    logic        valid;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
  } t_div_cache_entry;

endpackage

`default_nettype wire

// File: rtl/acc_div_inject_if.sv
// ============================================================================
// Module      : acc_div_inject_if
// Description : Handshake bundle between the accelerator controller and the
//               external iterative divider.
//   DivReq       master->slave  one-cycle start pulse
//   DivDividend  master->slave  registered dividend
//   DivDivisor   master->slave  registered divisor
//   DivDone      slave->master  result valid (single cycle)
//   Quotient     slave->master  quotient, valid with DivDone
//   Remainder    slave->master  remainder, valid with DivDone
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acc_div_inject_if #(
  parameter int DATA_W = 16
) ();

  logic              DivReq;
  logic [DATA_W-1:0] DivDividend;
  logic [DATA_W-1:0] DivDivisor;
  logic              DivDone;
  logic [DATA_W-1:0] Quotient;
  logic [DATA_W-1:0] Remainder;

  // Accelerator side
  modport master (
    output DivReq, DivDividend, DivDivisor,
    input  DivDone, Quotient, Remainder
  );

  // Divider side
  modport slave (
    input  DivReq, DivDividend, DivDivisor,
    output DivDone, Quotient, Remainder
  );

endinterface

`default_nettype wire

// File: rtl/acc_div_inject_result_cache.sv
// ============================================================================
// Module      : acc_div_inject_result_cache
// Description : Fully associative divide-result cache with round-robin fill.
//               Lookup is combinational against the live operands; a fill
//               that matches an existing valid entry overwrites that entry in
//               place and leaves the replacement pointer alone, so an operand
//               pair never occupies two entries.
// Ports       : Clk, Reset (async active-low)
//               lookup_dividend/lookup_divisor -> hit, hit_quotient,
//               hit_remainder
//               fill_en, fill_dividend, fill_divisor, fill_quotient,
//               fill_remainder
// Build       : instantiated only when ACC_RESULT_CACHE_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_div_inject_result_cache #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  wire logic              Clk,
  input  wire logic              Reset,
  input  wire logic [DATA_W-1:0] lookup_dividend,
  input  wire logic [DATA_W-1:0] lookup_divisor,
  output logic                   hit,
  output logic      [DATA_W-1:0] hit_quotient,
  output logic      [DATA_W-1:0] hit_remainder,
  input  wire logic              fill_en,
  input  wire logic [DATA_W-1:0] fill_dividend,
  input  wire logic [DATA_W-1:0] fill_divisor,
  input  wire logic [DATA_W-1:0] fill_quotient,
  input  wire logic [DATA_W-1:0] fill_remainder
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][DATA_W-1:0] dvd_q, dvd_d;
  logic [DEPTH-1:0][DATA_W-1:0] dvs_q, dvs_d;
  logic [DEPTH-1:0][DATA_W-1:0] quo_q, quo_d;
  logic [DEPTH-1:0][DATA_W-1:0] rem_q, rem_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;

  logic             fill_match;
  logic [PTR_W-1:0] fill_match_idx;
  logic [PTR_W-1:0] wr_idx;

  // Lookup against the live request operands.
  always_comb begin
    hit           = 1'b0;
    hit_quotient  = '0;
    hit_remainder = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (dvd_q[i] == lookup_dividend) && (dvs_q[i] == lookup_divisor)) begin
        hit           = 1'b1;
        hit_quotient  = quo_q[i];
        hit_remainder = rem_q[i];
      end
    end
  end

  // Fill: reuse a matching entry, otherwise take the round-robin slot.
  always_comb begin
    fill_match     = 1'b0;
    fill_match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (dvd_q[i] == fill_dividend) && (dvs_q[i] == fill_divisor)) begin
        fill_match     = 1'b1;
        fill_match_idx = PTR_W'(i);
      end
    end

    valid_d = valid_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    wr_idx  = fill_match ? fill_match_idx : ptr_q;

    if (fill_en) begin
      valid_d[wr_idx] = 1'b1;
      dvd_d[wr_idx]   = fill_dividend;
      dvs_d[wr_idx]   = fill_divisor;
      quo_d[wr_idx]   = fill_quotient;
      rem_d[wr_idx]   = fill_remainder;
      if (!fill_match) begin
        ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valid_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/acc_div_inject.sv
// ============================================================================
// Module      : acc_div_inject
// Description : Divide accelerator controller. Accepts a divide request from
//               decode, obtains quotient/remainder (divide-by-zero shortcut,
//               optional result cache, or the external divider) and injects
//               four two-instruction bundles that store Q to @ADDR_Q and R to
//               @ADDR_R. Values with the MSB set are loaded as @(~V) ; D=!A
//               since an A-instruction can only carry DATA_W-1 bits.
// Ports       : Clk, Reset (async active-low)
//               StartDiv102, Dividend, Divisor, PC100   request from decode
//               div_if (master)                          divider handshake
//               Inst0FromAcc101, Inst1FromAcc101         injected bundle
//               SelAccInst101, SelPcAcc, AccPc           pipeline steering
//               State                                    debug/perf
// Build       : ACC_RESULT_CACHE_EN enables the CACHE_DEPTH-entry result
//               cache; without it every nonzero-divisor request runs the
//               divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_div_inject
  import acc_div_inject_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 10,
  parameter int ADDR_Q      = 1,
  parameter int ADDR_R      = 2,
  parameter int CACHE_DEPTH = 4
) (
  input  wire logic              Clk,
  input  wire logic              Reset,
  input  wire logic              StartDiv102,
  input  wire logic [DATA_W-1:0] Dividend,
  input  wire logic [DATA_W-1:0] Divisor,
  input  wire logic [PC_W-1:0]   PC100,
  acc_div_inject_if.master       div_if,
  output logic      [DATA_W-1:0] Inst0FromAcc101,
  output logic      [DATA_W-1:0] Inst1FromAcc101,
  output logic                   SelAccInst101,
  output logic                   SelPcAcc,
  output logic      [PC_W-1:0]   AccPc,
  output t_acc_state             State
);

  localparam logic [DATA_W-1:0] C_AT_Q      = DATA_W'(ADDR_Q);
  localparam logic [DATA_W-1:0] C_AT_R      = DATA_W'(ADDR_R);
  localparam logic [DATA_W-1:0] C_LD_PLAIN  = DATA_W'(INST_D_EQ_A);
  localparam logic [DATA_W-1:0] C_LD_INVERT = DATA_W'(INST_D_EQ_NOT_A);
  localparam logic [DATA_W-1:0] C_ST        = DATA_W'(INST_M_EQ_D);

  t_acc_state        state_q, state_d;
  logic              idx_q, idx_d;
  logic [PC_W-1:0]   acc_pc_q, acc_pc_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              div_req_q, div_req_d;
  logic [DATA_W-1:0] inst0_q, inst0_d;
  logic [DATA_W-1:0] inst1_q, inst1_d;
  logic              sel_acc_q, sel_acc_d;
  logic              sel_pc_q, sel_pc_d;

  logic              cache_hit;
  logic [DATA_W-1:0] cache_quo;
  logic [DATA_W-1:0] cache_rem;
  logic              fill_en;
  logic [DATA_W-1:0] emit_val;

`ifdef ACC_RESULT_CACHE_EN
  acc_div_inject_result_cache #(
    .DATA_W (DATA_W),
    .DEPTH  (CACHE_DEPTH)
  ) u_cache (
    .Clk             (Clk),
    .Reset           (Reset),
    .lookup_dividend (Dividend),
    .lookup_divisor  (Divisor),
    .hit             (cache_hit),
    .hit_quotient    (cache_quo),
    .hit_remainder   (cache_rem),
    .fill_en         (fill_en),
    .fill_dividend   (dvd_q),
    .fill_divisor    (dvs_q),
    .fill_quotient   (div_if.Quotient),
    .fill_remainder  (div_if.Remainder)
  );
`else
  assign cache_hit = 1'b0;
  assign cache_quo = '0;
  assign cache_rem = '0;
  logic unused_cache_cfg;
  assign unused_cache_cfg = fill_en ^ (CACHE_DEPTH > 0);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_pc_d = acc_pc_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    fill_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (StartDiv102) begin
          dvd_d    = Dividend;
          dvs_d    = Divisor;
          acc_pc_d = PC100;
          idx_d    = 1'b0;
          if (Divisor == '0) begin
            quo_d   = '1;
            rem_d   = Dividend;
            state_d = S_EMIT_LD;
          end else if (cache_hit) begin
            quo_d   = cache_quo;
            rem_d   = cache_rem;
            state_d = S_EMIT_LD;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        if (div_if.DivDone) begin
          quo_d   = div_if.Quotient;
          rem_d   = div_if.Remainder;
          fill_en = 1'b1;
          state_d = S_EMIT_LD;
        end
      end
      S_EMIT_LD: state_d = S_EMIT_ST;
      S_EMIT_ST: begin
        if (!idx_q) begin
          idx_d   = 1'b1;
          state_d = S_EMIT_LD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from the next state so they register together
    // with it and always describe the current State.
    emit_val  = idx_d ? rem_d : quo_d;
    div_req_d = (state_d == S_DIV) && (state_q != S_DIV);
    sel_pc_d  = (state_d != S_IDLE);
    sel_acc_d = 1'b0;
    inst0_d   = '0;
    inst1_d   = '0;
    case (state_d)
      S_EMIT_LD: begin
        sel_acc_d = 1'b1;
        if (emit_val[DATA_W-1]) begin
          inst0_d = {1'b0, ~emit_val[DATA_W-2:0]};
          inst1_d = C_LD_INVERT;
        end else begin
          inst0_d = {1'b0, emit_val[DATA_W-2:0]};
          inst1_d = C_LD_PLAIN;
        end
      end
      S_EMIT_ST: begin
        sel_acc_d = 1'b1;
        inst0_d   = idx_d ? C_AT_R : C_AT_Q;
        inst1_d   = C_ST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 1'b0;
      acc_pc_q  <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_req_q <= 1'b0;
      inst0_q   <= '0;
      inst1_q   <= '0;
      sel_acc_q <= 1'b0;
      sel_pc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_pc_q  <= acc_pc_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_req_q <= div_req_d;
      inst0_q   <= inst0_d;
      inst1_q   <= inst1_d;
      sel_acc_q <= sel_acc_d;
      sel_pc_q  <= sel_pc_d;
    end
  end

  assign div_if.DivReq      = div_req_q;
  assign div_if.DivDividend = dvd_q;
  assign div_if.DivDivisor  = dvs_q;
  assign Inst0FromAcc101    = inst0_q;
  assign Inst1FromAcc101    = inst1_q;
  assign SelAccInst101      = sel_acc_q;
  assign SelPcAcc           = sel_pc_q;
  assign AccPc              = acc_pc_q;
  assign State              = state_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_div_inject.sv
// ============================================================================
// Module      : tb_acc_div_inject
// Description : Directed self-checking bench for acc_div_inject. The bench
//               plays decode and the external divider; expected bundles are
//               written out by hand for each request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_div_inject;
  import acc_div_inject_pkg::*;

`ifdef ACC_RESULT_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        StartDiv102;
  logic [15:0] Dividend;
  logic [15:0] Divisor;
  logic [9:0]  PC100;
  logic [15:0] Inst0FromAcc101;
  logic [15:0] Inst1FromAcc101;
  logic        SelAccInst101;
  logic        SelPcAcc;
  logic [9:0]  AccPc;
  t_acc_state  State;

  int n_cmp  = 0;
  int n_fail = 0;

  acc_div_inject_if #(.DATA_W(16)) div_if ();

  acc_div_inject dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .StartDiv102     (StartDiv102),
    .Dividend        (Dividend),
    .Divisor         (Divisor),
    .PC100           (PC100),
    .div_if          (div_if),
    .Inst0FromAcc101 (Inst0FromAcc101),
    .Inst1FromAcc101 (Inst1FromAcc101),
    .SelAccInst101   (SelAccInst101),
    .SelPcAcc        (SelPcAcc),
    .AccPc           (AccPc),
    .State           (State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(State), 32'(S_IDLE));
    chk({tag, "_selpc"}, 32'(SelPcAcc), 32'd0);
    chk({tag, "_selacc"}, 32'(SelAccInst101), 32'd0);
    chk({tag, "_inst0"}, 32'(Inst0FromAcc101), 32'd0);
    chk({tag, "_inst1"}, 32'(Inst1FromAcc101), 32'd0);
    chk({tag, "_divreq"}, 32'(div_if.DivReq), 32'd0);
  endtask

  // One full request. exp_miss selects whether the divider handshake is
  // expected; qa/qc and ra/rc are the load bundles for Q and R.
  task automatic do_req(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                        input logic [9:0] pc, input bit exp_miss, input logic [15:0] dq,
                        input logic [15:0] dr, input int delay, input logic [15:0] qa,
                        input logic [15:0] qc, input logic [15:0] ra, input logic [15:0] rc);
    logic [15:0] e0, e1;
    @(negedge Clk);
    StartDiv102 = 1'b1;
    Dividend    = dvd;
    Divisor     = dvs;
    PC100       = pc;
    @(posedge Clk);
    #1;
    StartDiv102 = 1'b0;
    Dividend    = 16'h0;
    Divisor     = 16'h0;
    PC100       = 10'h0;
    if (exp_miss) begin
      chk({tag, "_divreq"}, 32'(div_if.DivReq), 32'd1);
      chk({tag, "_divstate"}, 32'(State), 32'(S_DIV));
      chk({tag, "_divdvd"}, 32'(div_if.DivDividend), 32'(dvd));
      chk({tag, "_divdvs"}, 32'(div_if.DivDivisor), 32'(dvs));
      for (int k = 0; k < delay; k++) begin
        @(posedge Clk);
        #1;
        chk({tag, "_divreq_once"}, 32'(div_if.DivReq), 32'd0);
        chk({tag, "_divwait"}, 32'(State), 32'(S_DIV));
      end
      div_if.DivDone   = 1'b1;
      div_if.Quotient  = dq;
      div_if.Remainder = dr;
      @(posedge Clk);
      #1;
      div_if.DivDone   = 1'b0;
      div_if.Quotient  = 16'hBEEF;
      div_if.Remainder = 16'hBEEF;
    end
    chk({tag, "_accpc"}, 32'(AccPc), 32'(pc));
    for (int b = 0; b < 4; b++) begin
      e0 = (b == 0) ? qa : (b == 1) ? 16'h0001 : (b == 2) ? ra : 16'h0002;
      e1 = (b == 0) ? qc : (b == 2) ? rc : 16'hE308;
      chk($sformatf("%s_b%0d_state", tag, b), 32'(State),
          (b % 2 == 0) ? 32'(S_EMIT_LD) : 32'(S_EMIT_ST));
      chk($sformatf("%s_b%0d_selacc", tag, b), 32'(SelAccInst101), 32'd1);
      chk($sformatf("%s_b%0d_selpc", tag, b), 32'(SelPcAcc), 32'd1);
      chk($sformatf("%s_b%0d_inst0", tag, b), 32'(Inst0FromAcc101), 32'(e0));
      chk($sformatf("%s_b%0d_inst1", tag, b), 32'(Inst1FromAcc101), 32'(e1));
      chk($sformatf("%s_b%0d_divreq", tag, b), 32'(div_if.DivReq), 32'd0);
      @(posedge Clk);
      #1;
    end
    chk({tag, "_done_state"}, 32'(State), 32'(S_DONE));
    chk({tag, "_done_selpc"}, 32'(SelPcAcc), 32'd1);
    chk({tag, "_done_selacc"}, 32'(SelAccInst101), 32'd0);
    chk({tag, "_done_inst0"}, 32'(Inst0FromAcc101), 32'd0);
    chk({tag, "_done_inst1"}, 32'(Inst1FromAcc101), 32'd0);
    @(posedge Clk);
    #1;
    chk_idle({tag, "_end"});
  endtask

  initial begin
    Reset            = 1'b0;
    StartDiv102      = 1'b0;
    Dividend         = 16'h0;
    Divisor          = 16'h0;
    PC100            = 10'h0;
    div_if.DivDone   = 1'b0;
    div_if.Quotient  = 16'h0;
    div_if.Remainder = 16'h0;

    repeat (2) @(posedge Clk);
    #1;
    chk_idle("reset");
    chk("reset_accpc", 32'(AccPc), 32'd0);
    chk("reset_divdvd", 32'(div_if.DivDividend), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // 20000/10 = 2000 r 0, divider answers two cycles after DivReq.
    do_req("miss_20000_10", 16'd20000, 16'd10, 10'h05A, 1'b1, 16'd2000, 16'd0, 2,
           16'h07D0, 16'hEC10, 16'h0000, 16'hEC10);

    // Same operands: served from the cache when it is built in.
    do_req("rep_20000_10", 16'd20000, 16'd10, 10'h05B, !CACHE_ON, 16'd2000, 16'd0, 1,
           16'h07D0, 16'hEC10, 16'h0000, 16'hEC10);

    // MSB-set quotient, DivDone in the very first S_DIV cycle.
    do_req("msb_65535_1", 16'hFFFF, 16'd1, 10'h100, 1'b1, 16'hFFFF, 16'h0000, 0,
           16'h0000, 16'hEC50, 16'h0000, 16'hEC10);

    // Divide by zero: Q all-ones, R dividend, no divider.
    do_req("divzero", 16'h1234, 16'd0, 10'h3FF, 1'b0, 16'h0, 16'h0, 0,
           16'h0000, 16'hEC50, 16'h1234, 16'hEC10);

    // Reset during the quotient store bundle.
    @(negedge Clk);
    StartDiv102 = 1'b1;
    Dividend    = 16'd100;
    Divisor     = 16'd7;
    PC100       = 10'h077;
    @(posedge Clk);
    #1;
    StartDiv102 = 1'b0;
    chk("rst_run_divreq", 32'(div_if.DivReq), 32'd1);
    div_if.DivDone   = 1'b1;
    div_if.Quotient  = 16'd14;
    div_if.Remainder = 16'd2;
    @(posedge Clk);
    #1;
    div_if.DivDone = 1'b0;
    chk("rst_run_ldq", 32'(Inst0FromAcc101), 32'h000E);
    @(posedge Clk);
    #1;
    chk("rst_run_stq_state", 32'(State), 32'(S_EMIT_ST));
    chk("rst_run_stq_inst0", 32'(Inst0FromAcc101), 32'h0001);
    Reset = 1'b0;
    #1;
    chk_idle("rst_async");
    chk("rst_async_accpc", 32'(AccPc), 32'd0);
    chk("rst_async_divdvd", 32'(div_if.DivDividend), 32'd0);
    chk("rst_async_divdvs", 32'(div_if.DivDivisor), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk_idle("rst_stays_idle");

    // Reset also emptied the cache, so this is a full miss sequence.
    do_req("after_rst_100_7", 16'd100, 16'd7, 10'h077, 1'b1, 16'd14, 16'd2, 1,
           16'h000E, 16'hEC10, 16'h0002, 16'hEC10);

    // Fresh cache, five distinct misses: the fifth evicts the first.
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    do_req("fill_a_30_4", 16'd30, 16'd4, 10'h010, 1'b1, 16'd7, 16'd2, 1,
           16'h0007, 16'hEC10, 16'h0002, 16'hEC10);
    do_req("fill_b_31_4", 16'd31, 16'd4, 10'h011, 1'b1, 16'd7, 16'd3, 1,
           16'h0007, 16'hEC10, 16'h0003, 16'hEC10);
    do_req("fill_c_32_4", 16'd32, 16'd4, 10'h012, 1'b1, 16'd8, 16'd0, 1,
           16'h0008, 16'hEC10, 16'h0000, 16'hEC10);
    do_req("fill_d_33_4", 16'd33, 16'd4, 10'h013, 1'b1, 16'd8, 16'd1, 1,
           16'h0008, 16'hEC10, 16'h0001, 16'hEC10);
    do_req("fill_e_34_4", 16'd34, 16'd4, 10'h014, 1'b1, 16'd8, 16'd2, 1,
           16'h0008, 16'hEC10, 16'h0002, 16'hEC10);
    do_req("reuse_b_31_4", 16'd31, 16'd4, 10'h020, !CACHE_ON, 16'd7, 16'd3, 1,
           16'h0007, 16'hEC10, 16'h0003, 16'hEC10);
    do_req("evicted_a_30_4", 16'd30, 16'd4, 10'h021, 1'b1, 16'd7, 16'd2, 1,
           16'h0007, 16'hEC10, 16'h0002, 16'hEC10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
